// File: rtl/mult_wb_fifo_if.sv
// Bus between the mult unit, the result buffer and the writeback arbiter.
// Mult side: valid/result/trans_id. Writeback side: wb_valid/wb_result/wb_trans_id/wb_ready.
interface mult_wb_fifo_if #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 4
);
  logic                     valid;
  logic [XLEN-1:0]          result;
  logic [TRANS_ID_BITS-1:0] trans_id;
  logic                     wb_valid;
  logic [XLEN-1:0]          wb_result;
  logic [TRANS_ID_BITS-1:0] wb_trans_id;
  logic                     wb_ready;

  // Buffer side
  modport slave (
    input  valid, result, trans_id, wb_ready,
    output wb_valid, wb_result, wb_trans_id
  );

  // Environment side (mult unit + writeback arbiter)
  modport master (
    output valid, result, trans_id, wb_ready,
    input  wb_valid, wb_result, wb_trans_id
  );
endinterface

// File: rtl/mult_wb_fifo.sv
// Result buffer behind the non-stallable mult pipeline. Captures each result pulse,
// presents the oldest entry to writeback, and throttles issue so the buffer never overflows.
// XLEN / TRANS_ID_BITS stand in for the core-configuration values.
module mult_wb_fifo #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned RESERVE       = 2,
  localparam int unsigned CW           = $clog2(DEPTH + 1),
  localparam int unsigned PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  mult_wb_fifo_if.slave        bus,
  output logic                 issue_ready_o,
  output logic [CW-1:0]        count_o,
  output logic                 overflow_o
);

  if (DEPTH < 2 || DEPTH <= RESERVE) begin : g_param_chk
    $error("mult_wb_fifo: need DEPTH >= 2 and DEPTH > RESERVE");
  end

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] RESERVE_C = CW'(RESERVE);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, full, wr_en;

  // Handshake decode. Full + pop still accepts a push since the head slot frees this cycle.
  always_comb begin
    push  = bus.valid & ~flush_i;
    pop   = bus.wb_valid & bus.wb_ready;
    full  = (count_q == DEPTH_C);
    wr_en = push & (~full | pop);
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; occupancy qualifies every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{result: bus.result, trans_id: bus.trans_id};
  end

  // Outputs depend only on registered state and flush_i, never on wb_ready.
  always_comb begin
    bus.wb_valid    = (count_q != '0) & ~flush_i;
    bus.wb_result   = mem_q[rd_ptr_q].result;
    bus.wb_trans_id = mem_q[rd_ptr_q].trans_id;
    issue_ready_o   = ~flush_i & ((DEPTH_C - count_q) > RESERVE_C);
    count_o         = count_q;
    overflow_o      = overflow_q;
  end

endmodule

// File: tb/tb_mult_wb_fifo.sv
// Directed bench for mult_wb_fifo (DEPTH=4, RESERVE=2).
module tb_mult_wb_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       issue_ready;
  logic [2:0] count;
  logic       overflow;
  int         total  = 0;
  int         passed = 0;

  mult_wb_fifo_if #(.XLEN(64), .TRANS_ID_BITS(4)) bus ();

  mult_wb_fifo #(.XLEN(64), .TRANS_ID_BITS(4), .DEPTH(4), .RESERVE(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus),
    .issue_ready_o(issue_ready), .count_o(count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic [3:0] id, input logic rdy);
    bus.valid    = v;
    bus.result   = r;
    bus.trans_id = id;
    bus.wb_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single push, visible next cycle, popped the cycle after
    drive(1'b1, 64'hDEAD, 4'd3, 1'b1);
    chk("t1_no_bypass", 64'(bus.wb_valid), 64'd0);
    tick();
    drive(1'b0, 64'h0, 4'h0, 1'b1);
    chk("t1_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_result", bus.wb_result, 64'hDEAD);
    chk("t1_id", 64'(bus.wb_trans_id), 64'd3);
    chk("t1_count1", 64'(count), 64'd1);
    tick();
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_empty", 64'(bus.wb_valid), 64'd0);

    // 2: fill to 4 with ready low; issue_ready drops once count reaches 2
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(100 + i), 4'(i), 1'b0);
      tick();
      chk("t2_fill_count", 64'(count), 64'(i + 1));
      chk("t2_issue_ready", 64'(issue_ready), (i == 0) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    tick();
    chk("t2_hold_id", 64'(bus.wb_trans_id), 64'd0);
    chk("t2_hold_res", bus.wb_result, 64'd100);
    chk("t2_count4", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 4'h0, 1'b1);
      if (i == 2) begin
        bus.wb_ready = 1'b0;
        tick();
        chk("t2_stall_id", 64'(bus.wb_trans_id), 64'd2);
        chk("t2_stall_res", bus.wb_result, 64'd102);
        bus.wb_ready = 1'b1;
        #1;
      end
      chk("t2_drain_id", 64'(bus.wb_trans_id), 64'(i));
      chk("t2_drain_res", bus.wb_result, 64'(100 + i));
      tick();
    end
    chk("t2_drained", 64'(count), 64'd0);

    // 3: push while full and popping -> accepted, no overflow
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(200 + i), 4'(i), 1'b0);
      tick();
    end
    drive(1'b1, 64'd207, 4'd7, 1'b1);
    tick();
    drive(1'b0, 64'h0, 4'h0, 1'b1);
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_overflow", 64'(overflow), 64'd0);
    chk("t3_id0", 64'(bus.wb_trans_id), 64'd1); tick();
    chk("t3_id1", 64'(bus.wb_trans_id), 64'd2); tick();
    chk("t3_id2", 64'(bus.wb_trans_id), 64'd3); tick();
    chk("t3_id3", 64'(bus.wb_trans_id), 64'd7);
    chk("t3_res3", bus.wb_result, 64'd207);     tick();
    chk("t3_empty", 64'(bus.wb_valid), 64'd0);

    // 4: push while full, no pop -> dropped, overflow sticks
    drive(1'b1, 64'd304, 4'd4, 1'b0); tick();
    drive(1'b1, 64'd305, 4'd5, 1'b0); tick();
    drive(1'b1, 64'd306, 4'd6, 1'b0); tick();
    drive(1'b1, 64'd308, 4'd8, 1'b0); tick();
    drive(1'b1, 64'd309, 4'd9, 1'b0); tick();
    drive(1'b0, 64'h0, 4'h0, 1'b1);
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_head", 64'(bus.wb_trans_id), 64'd4);
    tick();
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    chk("t4_count3", 64'(count), 64'd3);

    // 5: flush with 3 buffered, valid and ready high
    flush = 1'b1;
    drive(1'b1, 64'hAAAA, 4'hA, 1'b1);
    chk("t5_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("t5_issue_ready", 64'(issue_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 4'h0, 1'b1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_wb_valid_after", 64'(bus.wb_valid), 64'd0);
    chk("t5_overflow_sticky", 64'(overflow), 64'd1);
    tick();
    chk("t5_still_empty", 64'(bus.wb_valid), 64'd0);

    // 6: ten back-to-back push/pop pairs across the pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 64'(16'h1000 + k), 4'(k), 1'b1);
      if (k > 0) begin
        chk("t6_id", 64'(bus.wb_trans_id), 64'(k - 1));
        chk("t6_res", bus.wb_result, 64'(16'h1000 + k - 1));
        chk("t6_count", 64'(count), 64'd1);
      end
      tick();
    end
    drive(1'b0, 64'h0, 4'h0, 1'b1);
    chk("t6_last_id", 64'(bus.wb_trans_id), 64'd9);
    chk("t6_last_valid", 64'(bus.wb_valid), 64'd1);
    tick();
    chk("t6_empty", 64'(count), 64'd0);

    // Async reset mid-operation clears state immediately
    drive(1'b1, 64'h55, 4'd1, 1'b0); tick(); tick();
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    chk("ar_count_pre", 64'(count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("ar_overflow", 64'(overflow), 64'd0);
    chk("ar_issue_ready", 64'(issue_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
